// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: shares picture BRAM port A between the UART image loader
// (requester 0) and the filter write-back engine (requester 1). Bursts are granted
// round-robin with a cap on beats per grant. Read data is routed back through a
// tag pipeline that matches the BRAM read latency.
module bram_port_arbiter #(
    parameter int ADDR_W     = 19,
    parameter int DATA_W     = 18,
    parameter int RD_LATENCY = 2,
    parameter int MAX_BURST  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic              last0,
    input  logic              last1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_din,
    input  logic [DATA_W-1:0] bram_dout
);

    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_nextState;
    logic                  r_lastServed;
    logic [CNT_W-1:0]      r_burstCnt;
    logic [RD_LATENCY-1:0] r_rdValid;
    logic [RD_LATENCY-1:0] r_rdTag;

    logic w_ack0;
    logic w_ack1;
    logic w_accept;
    logic w_beatWe;
    logic w_beatLast;
    logic w_capHit;
    logic w_grantEnd;

    // The owner's pending beat is accepted in the same cycle it is presented.
    assign w_ack0     = (r_state == OWN0) && req0;
    assign w_ack1     = (r_state == OWN1) && req1;
    assign w_accept   = w_ack0 || w_ack1;
    assign w_beatWe   = (r_state == OWN1) ? we1 : we0;
    assign w_beatLast = (r_state == OWN1) ? last1 : last0;
    assign w_capHit   = (r_burstCnt == CNT_W'(MAX_BURST - 1));
    assign w_grantEnd = w_accept && (w_beatLast || w_capHit);

    assign ack0 = w_ack0;
    assign ack1 = w_ack1;
    assign gnt0 = (r_state == OWN0);
    assign gnt1 = (r_state == OWN1);

    // State register for the grant FSM.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state: arbitrate in IDLE, release the port when the burst ends or hits the cap.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (req0 && req1) begin
                    w_nextState = r_lastServed ? OWN0 : OWN1;
                end else if (req0) begin
                    w_nextState = OWN0;
                end else if (req1) begin
                    w_nextState = OWN1;
                end
            end
            OWN0, OWN1: begin
                if (w_grantEnd) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Track beats in the current grant and remember who was served last for the tie-break.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lastServed <= 1'b1;
            r_burstCnt   <= '0;
        end else if (w_grantEnd) begin
            r_lastServed <= (r_state == OWN1);
            r_burstCnt   <= '0;
        end else if (w_accept) begin
            r_burstCnt   <= r_burstCnt + CNT_W'(1);
        end
    end

    // Port mux: the owner's address/data are always presented; enable only on an accepted beat.
    always_comb begin
        bram_en   = w_accept;
        bram_we   = w_accept && w_beatWe;
        bram_addr = '0;
        bram_din  = '0;
        case (r_state)
            OWN0: begin
                bram_addr = addr0;
                bram_din  = wdata0;
            end
            OWN1: begin
                bram_addr = addr1;
                bram_din  = wdata1;
            end
            default: begin
                bram_addr = '0;
                bram_din  = '0;
            end
        endcase
    end

    // Read-return pipeline: one slot per cycle of BRAM latency, carrying valid and requester tag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rdValid <= '0;
            r_rdTag   <= '0;
        end else begin
            r_rdValid[0] <= w_accept && !w_beatWe;
            r_rdTag[0]   <= (r_state == OWN1);
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_rdValid[i] <= r_rdValid[i-1];
                r_rdTag[i]   <= r_rdTag[i-1];
            end
        end
    end

    assign rvalid0 = r_rdValid[RD_LATENCY-1] && !r_rdTag[RD_LATENCY-1];
    assign rvalid1 = r_rdValid[RD_LATENCY-1] &&  r_rdTag[RD_LATENCY-1];
    assign rdata   = bram_dout;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb_bram_port_arbiter: directed scenarios plus a randomized run for bram_port_arbiter,
// with a BRAM model on the port and a transaction-level scoreboard in the bench.
module tb_bram_port_arbiter;

    localparam int ADDR_W = 19;
    localparam int DATA_W = 18;
    localparam int RD_LAT = 2;
    localparam int MAXB   = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0, last0 = 1'b0, last1 = 1'b0;
    logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
    logic [DATA_W-1:0] wdata0 = '0, wdata1 = '0;
    logic              ack0, ack1, gnt0, gnt1, rvalid0, rvalid1;
    logic [DATA_W-1:0] rdata;
    logic              bram_en, bram_we;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_din;
    logic [DATA_W-1:0] bram_dout;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic              we;
        logic              last;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        int                start;
    } beat_t;

    typedef struct {
        int                cyc;
        int                id;
        logic              en;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] din;
        logic              bWe;
        logic              bLast;
        logic [ADDR_W-1:0] bAddr;
        logic [DATA_W-1:0] bData;
        logic [DATA_W-1:0] expRd;
    } ack_t;

    typedef struct {
        int                cyc;
        int                id;
        logic [DATA_W-1:0] data;
    } rv_t;

    beat_t      q0[$];
    beat_t      q1[$];
    ack_t       ackLog[$];
    rv_t        rvLog[$];
    logic [1:0] gntHist[$];
    logic [1:0] reqHist[$];
    logic [DATA_W-1:0] refMem [0:1023];

    // Free-running clock.
    always #5 clk = ~clk;

    bram_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LATENCY(RD_LAT), .MAX_BURST(MAXB)
    ) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1), .last0(last0), .last1(last1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .gnt0(gnt0), .gnt1(gnt1),
        .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
        .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
        .bram_dout(bram_dout)
    );

    // BRAM model: synchronous write, read data appears RD_LAT cycles after the read beat.
    logic              clearMem = 1'b0;
    logic [DATA_W-1:0] mem      [0:1023];
    logic [DATA_W-1:0] doutPipe [0:RD_LAT-1];

    always @(posedge clk) begin
        if (clearMem) begin
            for (int i = 0; i < 1024; i++) mem[i] <= '0;
        end else if (bram_en && bram_we) begin
            mem[bram_addr[9:0]] <= bram_din;
        end
        doutPipe[0] <= (bram_en && !bram_we) ? mem[bram_addr[9:0]] : '0;
        for (int i = 1; i < RD_LAT; i++) doutPipe[i] <= doutPipe[i-1];
    end

    assign bram_dout = doutPipe[RD_LAT-1];

    task automatic idleInputs();
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0; last0 = 1'b0; last1 = 1'b0;
    endtask

    task automatic applyReset();
        @(posedge clk); #1;
        reset = 1'b0;
        idleInputs();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic pushBeat(input int id, input logic we, input logic last, input int addr,
                            input logic [DATA_W-1:0] data, input int start);
        beat_t b;
        b.we = we; b.last = last; b.addr = ADDR_W'(addr); b.data = data; b.start = start;
        if (id == 0) q0.push_back(b);
        else q1.push_back(b);
    endtask

    task automatic pushBurst(input int id, input int n, input logic we, input int base, input int start);
        for (int i = 0; i < n; i++) pushBeat(id, we, i == n - 1, base + i, DATA_W'($urandom), start);
    endtask

    // Monitor side of an accepted beat: log port values and the beat that was consumed.
    task automatic recordAck(input int c, input int id);
        ack_t  a;
        beat_t b;
        b = '{we: 1'b0, last: 1'b0, addr: '0, data: '0, start: 0};
        if (id == 0 && q0.size() > 0) b = q0.pop_front();
        if (id == 1 && q1.size() > 0) b = q1.pop_front();
        a.cyc = c; a.id = id; a.en = bram_en; a.we = bram_we; a.addr = bram_addr; a.din = bram_din;
        a.bWe = b.we; a.bLast = b.last; a.bAddr = b.addr; a.bData = b.data;
        a.expRd = refMem[b.addr[9:0]];
        if (b.we) refMem[b.addr[9:0]] = b.data;
        ackLog.push_back(a);
    endtask

    // Drives both requesters from their beat queues for nCycles and records what the DUT did.
    task automatic runAgents(input int nCycles);
        ackLog.delete(); rvLog.delete(); gntHist.delete(); reqHist.delete();
        for (int c = 0; c < nCycles; c++) begin
            if (q0.size() > 0 && c >= q0[0].start) begin
                req0 = 1'b1; we0 = q0[0].we; last0 = q0[0].last; addr0 = q0[0].addr; wdata0 = q0[0].data;
            end else begin
                req0 = 1'b0; we0 = 1'b0; last0 = 1'b0;
            end
            if (q1.size() > 0 && c >= q1[0].start) begin
                req1 = 1'b1; we1 = q1[0].we; last1 = q1[0].last; addr1 = q1[0].addr; wdata1 = q1[0].data;
            end else begin
                req1 = 1'b0; we1 = 1'b0; last1 = 1'b0;
            end
            @(negedge clk);
            gntHist.push_back({gnt1, gnt0});
            reqHist.push_back({req1, req0});
            if (rvalid0) rvLog.push_back('{cyc: c, id: 0, data: rdata});
            if (rvalid1) rvLog.push_back('{cyc: c, id: 1, data: rdata});
            if (ack0) recordAck(c, 0);
            if (ack1) recordAck(c, 1);
            @(posedge clk); #1;
        end
        idleInputs();
    endtask

    // Everything is quiet and zero while reset is held, even with requests pending.
    task automatic test_reset();
        req0 = 1'b1; req1 = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        total++;
        if ({gnt0, gnt1, ack0, ack1, rvalid0, rvalid1, bram_en, bram_we} !== 8'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 00000000", {gnt0, gnt1, ack0, ack1, rvalid0, rvalid1, bram_en, bram_we});
        end
        total++;
        if (bram_addr !== '0 || bram_din !== '0) begin
            bad++;
            $display("FAIL reset_bus: got addr=%0h din=%0h want 0/0", bram_addr, bram_din);
        end
        idleInputs();
        reset = 1'b1;
        @(negedge clk);
        total++;
        if ({gnt0, gnt1, bram_en} !== 3'b0) begin
            bad++;
            $display("FAIL reset_release_idle: got %b want 000", {gnt0, gnt1, bram_en});
        end
        @(posedge clk); #1;
    endtask

    // A single 4-beat write burst from requester 0.
    task automatic test_write_burst();
        logic [1:0] expG;
        pushBurst(0, 4, 1'b1, 0, 0);
        runAgents(8);
        total++;
        if (ackLog.size() !== 4) begin
            bad++;
            $display("FAIL wr_count: got %0d acks want 4", ackLog.size());
        end
        for (int i = 0; i < ackLog.size() && i < 4; i++) begin
            total++;
            if (ackLog[i].cyc !== 1 + i || ackLog[i].id !== 0 || {ackLog[i].en, ackLog[i].we} !== 2'b11 ||
                ackLog[i].addr !== ADDR_W'(i) || ackLog[i].din !== ackLog[i].bData) begin
                bad++;
                $display("FAIL wr_beat%0d: got cyc=%0d id=%0d en/we=%b%b addr=%0h din=%0h want cyc=%0d id=0 en/we=11 addr=%0h din=%0h",
                         i, ackLog[i].cyc, ackLog[i].id, ackLog[i].en, ackLog[i].we, ackLog[i].addr, ackLog[i].din,
                         1 + i, i, ackLog[i].bData);
            end
        end
        for (int c = 0; c < 8; c++) begin
            expG = (c >= 1 && c <= 4) ? 2'b01 : 2'b00;
            total++;
            if (gntHist[c] !== expG) begin
                bad++;
                $display("FAIL wr_gnt_c%0d: got %b want %b", c, gntHist[c], expG);
            end
        end
    endtask

    // Simultaneous requests after reset: 0 wins, then 1; a re-request by 0 while 1 waits loses.
    task automatic test_round_robin();
        int expCyc [8] = '{1, 2, 4, 5, 7, 8, 10, 11};
        int expId  [8] = '{0, 0, 1, 1, 0, 0, 1, 1};
        int expAdr [8] = '{32'h20, 32'h21, 32'h30, 32'h31, 32'h22, 32'h23, 32'h32, 32'h33};
        applyReset();
        pushBurst(0, 2, 1'b1, 32'h20, 0);
        pushBurst(0, 2, 1'b1, 32'h22, 0);
        pushBurst(1, 2, 1'b1, 32'h30, 0);
        pushBurst(1, 2, 1'b1, 32'h32, 0);
        runAgents(16);
        total++;
        if (ackLog.size() !== 8) begin
            bad++;
            $display("FAIL rr_count: got %0d acks want 8", ackLog.size());
        end
        for (int i = 0; i < ackLog.size() && i < 8; i++) begin
            total++;
            if (ackLog[i].cyc !== expCyc[i] || ackLog[i].id !== expId[i] || ackLog[i].addr !== ADDR_W'(expAdr[i])) begin
                bad++;
                $display("FAIL rr_beat%0d: got cyc=%0d id=%0d addr=%0h want cyc=%0d id=%0d addr=%0h",
                         i, ackLog[i].cyc, ackLog[i].id, ackLog[i].addr, expCyc[i], expId[i], expAdr[i]);
            end
        end
    endtask

    // Requester 1 writes two colours, then reads them back with the fixed latency.
    task automatic test_read_return();
        pushBeat(1, 1'b1, 1'b0, 10, 18'h3F000, 0);
        pushBeat(1, 1'b1, 1'b1, 11, 18'h00FC0, 0);
        pushBurst(1, 2, 1'b0, 10, 0);
        runAgents(12);
        total++;
        if (ackLog.size() !== 4) begin
            bad++;
            $display("FAIL rd_count: got %0d acks want 4", ackLog.size());
        end else begin
            total++;
            if (ackLog[2].cyc !== 4 || ackLog[3].cyc !== 5 || ackLog[2].we !== 1'b0 || ackLog[3].we !== 1'b0) begin
                bad++;
                $display("FAIL rd_ack: got cyc=%0d,%0d we=%b%b want cyc=4,5 we=00",
                         ackLog[2].cyc, ackLog[3].cyc, ackLog[2].we, ackLog[3].we);
            end
        end
        total++;
        if (rvLog.size() !== 2) begin
            bad++;
            $display("FAIL rd_rvcount: got %0d returns want 2", rvLog.size());
        end else begin
            total++;
            if (rvLog[0].cyc !== 6 || rvLog[0].id !== 1 || rvLog[0].data !== 18'h3F000) begin
                bad++;
                $display("FAIL rd_ret0: got cyc=%0d id=%0d data=%0h want cyc=6 id=1 data=3f000",
                         rvLog[0].cyc, rvLog[0].id, rvLog[0].data);
            end
            total++;
            if (rvLog[1].cyc !== 7 || rvLog[1].id !== 1 || rvLog[1].data !== 18'h00FC0) begin
                bad++;
                $display("FAIL rd_ret1: got cyc=%0d id=%0d data=%0h want cyc=7 id=1 data=fc0",
                         rvLog[1].cyc, rvLog[1].id, rvLog[1].data);
            end
        end
    endtask

    // Requester 0 streams 10 beats with MAX_BURST=4 while requester 1 waits.
    task automatic test_max_burst();
        int expCyc [12] = '{1, 2, 3, 4, 6, 7, 9, 10, 11, 12, 14, 15};
        int expId  [12] = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0};
        int expAdr [12] = '{100, 101, 102, 103, 200, 201, 104, 105, 106, 107, 108, 109};
        applyReset();
        pushBurst(0, 10, 1'b1, 100, 0);
        pushBurst(1, 2, 1'b1, 200, 0);
        runAgents(20);
        total++;
        if (ackLog.size() !== 12) begin
            bad++;
            $display("FAIL cap_count: got %0d acks want 12", ackLog.size());
        end
        for (int i = 0; i < ackLog.size() && i < 12; i++) begin
            total++;
            if (ackLog[i].cyc !== expCyc[i] || ackLog[i].id !== expId[i] || ackLog[i].addr !== ADDR_W'(expAdr[i])) begin
                bad++;
                $display("FAIL cap_beat%0d: got cyc=%0d id=%0d addr=%0d want cyc=%0d id=%0d addr=%0d",
                         i, ackLog[i].cyc, ackLog[i].id, ackLog[i].addr, expCyc[i], expId[i], expAdr[i]);
            end
        end
    endtask

    // Reads from both requesters back to back; returns keep issue order across grants.
    task automatic test_back_to_back();
        int                rvCyc [5] = '{3, 4, 5, 7, 8};
        int                rvId  [5] = '{0, 0, 0, 1, 1};
        logic [DATA_W-1:0] rvDat [5];
        rvDat[0] = refMem[0]; rvDat[1] = refMem[1]; rvDat[2] = refMem[2];
        rvDat[3] = 18'h3F000; rvDat[4] = 18'h00FC0;
        applyReset();
        pushBurst(0, 3, 1'b0, 0, 0);
        pushBurst(1, 2, 1'b0, 10, 0);
        runAgents(14);
        total++;
        if (rvLog.size() !== 5) begin
            bad++;
            $display("FAIL b2b_count: got %0d returns want 5", rvLog.size());
        end
        for (int i = 0; i < rvLog.size() && i < 5; i++) begin
            total++;
            if (rvLog[i].cyc !== rvCyc[i] || rvLog[i].id !== rvId[i] || rvLog[i].data !== rvDat[i]) begin
                bad++;
                $display("FAIL b2b_ret%0d: got cyc=%0d id=%0d data=%0h want cyc=%0d id=%0d data=%0h",
                         i, rvLog[i].cyc, rvLog[i].id, rvLog[i].data, rvCyc[i], rvId[i], rvDat[i]);
            end
        end
    endtask

    // Reset in the cycle after an accepted read drops everything, including the in-flight read.
    task automatic test_reset_midburst();
        int seen = 0;
        applyReset();
        req0 = 1'b1; we0 = 1'b0; last0 = 1'b0; addr0 = ADDR_W'(5);
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if ({gnt0, ack0} !== 2'b11) begin
            bad++;
            $display("FAIL rstmid_ack: got gnt0/ack0=%b want 11", {gnt0, ack0});
        end
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        total++;
        if ({gnt0, gnt1, rvalid0, rvalid1, bram_en} !== 5'b0) begin
            bad++;
            $display("FAIL rstmid_clear: got %b want 00000", {gnt0, gnt1, rvalid0, rvalid1, bram_en});
        end
        idleInputs();
        @(posedge clk); #1;
        reset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rvalid0 || rvalid1 || gnt0 || gnt1) seen++;
            @(posedge clk); #1;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL rstmid_stale: got %0d active cycles after release want 0", seen);
        end
    endtask

    // Random bursts from both requesters checked against arbitration and return rules.
    task automatic test_random();
        localparam int NC = 600;
        int   errs, st, nb, len, p, runCnt, lastOwner;
        logic we, ends;
        logic [1:0] expG;
        rv_t  expRv[$];
        applyReset();
        for (int id = 0; id < 2; id++) begin
            st = $urandom_range(0, 3);
            nb = $urandom_range(4, 6);
            for (int b = 0; b < nb; b++) begin
                len = $urandom_range(1, 6);
                we  = 1'($urandom_range(0, 1));
                p   = $urandom_range(0, 60);
                for (int k = 0; k < len; k++) begin
                    if (k > 0 && $urandom_range(0, 4) == 0) st += $urandom_range(1, 3);
                    pushBeat(id, we, k == len - 1, p + k, DATA_W'($urandom), st);
                end
                st += $urandom_range(0, 6);
            end
        end
        runAgents(NC);

        total++;
        if (q0.size() !== 0 || q1.size() !== 0) begin
            bad++;
            $display("FAIL rand_drain: got %0d/%0d beats left want 0/0", q0.size(), q1.size());
        end

        errs = 0;
        foreach (ackLog[i]) begin
            if (ackLog[i].en !== 1'b1 || ackLog[i].we !== ackLog[i].bWe ||
                ackLog[i].addr !== ackLog[i].bAddr || ackLog[i].din !== ackLog[i].bData) begin
                if (errs == 0) $display("FAIL rand_port: ack %0d got en=%b we=%b addr=%0h din=%0h want 1/%b/%0h/%0h",
                                        i, ackLog[i].en, ackLog[i].we, ackLog[i].addr, ackLog[i].din,
                                        ackLog[i].bWe, ackLog[i].bAddr, ackLog[i].bData);
                errs++;
            end
        end
        total++;
        if (errs != 0) bad++;

        errs = 0;
        foreach (ackLog[i]) begin
            expG = (ackLog[i].id == 1) ? 2'b10 : 2'b01;
            if (gntHist[ackLog[i].cyc] !== expG || (i > 0 && ackLog[i].cyc == ackLog[i-1].cyc)) begin
                if (errs == 0) $display("FAIL rand_ackgnt: cyc %0d got gnt=%b for ack id %0d want %b",
                                        ackLog[i].cyc, gntHist[ackLog[i].cyc], ackLog[i].id, expG);
                errs++;
            end
        end
        total++;
        if (errs != 0) bad++;

        errs = 0;
        for (int c = 1; c < NC; c++) begin
            if (gntHist[c] === 2'b11 || (gntHist[c] !== 2'b00 && gntHist[c-1] !== 2'b00 && gntHist[c] !== gntHist[c-1])) begin
                if (errs == 0) $display("FAIL rand_gap: cyc %0d got gnt %b after %b want an idle cycle between owners",
                                        c, gntHist[c], gntHist[c-1]);
                errs++;
            end
        end
        total++;
        if (errs != 0) bad++;

        errs = 0; p = 0; runCnt = 0;
        for (int c = 0; c < NC - 1; c++) begin
            if (gntHist[c] === 2'b00) begin
                runCnt = 0;
            end else if (p < ackLog.size() && ackLog[p].cyc == c) begin
                runCnt++;
                ends = ackLog[p].bLast || (runCnt == MAXB);
                if (runCnt > MAXB || (ends && gntHist[c+1] !== 2'b00) || (!ends && gntHist[c+1] === 2'b00)) begin
                    if (errs == 0) $display("FAIL rand_burst: cyc %0d got beat %0d next gnt=%b want end=%b",
                                            c, runCnt, gntHist[c+1], ends);
                    errs++;
                end
            end else if (gntHist[c+1] === 2'b00) begin
                if (errs == 0) $display("FAIL rand_burst: cyc %0d got grant dropped without a beat want held", c);
                errs++;
            end
            while (p < ackLog.size() && ackLog[p].cyc <= c) p++;
        end
        total++;
        if (errs != 0) bad++;

        errs = 0; lastOwner = 1;
        for (int c = 0; c < NC - 1; c++) begin
            if (gntHist[c] === 2'b00) begin
                case (reqHist[c])
                    2'b11:   expG = (lastOwner == 1) ? 2'b01 : 2'b10;
                    2'b01:   expG = 2'b01;
                    2'b10:   expG = 2'b10;
                    default: expG = 2'b00;
                endcase
                if (gntHist[c+1] !== expG) begin
                    if (errs == 0) $display("FAIL rand_arb: cyc %0d req=%b got next gnt=%b want %b",
                                            c, reqHist[c], gntHist[c+1], expG);
                    errs++;
                end
            end else begin
                lastOwner = (gntHist[c] === 2'b10) ? 1 : 0;
            end
        end
        total++;
        if (errs != 0) bad++;

        foreach (ackLog[i]) begin
            if (!ackLog[i].bWe && ackLog[i].cyc + RD_LAT < NC)
                expRv.push_back('{cyc: ackLog[i].cyc + RD_LAT, id: ackLog[i].id, data: ackLog[i].expRd});
        end
        errs = 0;
        if (rvLog.size() != expRv.size()) begin
            $display("FAIL rand_rdata: got %0d returns want %0d", rvLog.size(), expRv.size());
            errs++;
        end
        for (int i = 0; i < rvLog.size() && i < expRv.size(); i++) begin
            if (rvLog[i].cyc !== expRv[i].cyc || rvLog[i].id !== expRv[i].id || rvLog[i].data !== expRv[i].data) begin
                if (errs == 0) $display("FAIL rand_rdata: ret %0d got cyc=%0d id=%0d data=%0h want cyc=%0d id=%0d data=%0h",
                                        i, rvLog[i].cyc, rvLog[i].id, rvLog[i].data,
                                        expRv[i].cyc, expRv[i].id, expRv[i].data);
                errs++;
            end
        end
        total++;
        if (errs != 0) bad++;
    endtask

    // Test sequence.
    initial begin
        for (int i = 0; i < 1024; i++) refMem[i] = '0;
        clearMem = 1'b1;
        @(posedge clk); #1;
        clearMem = 1'b0;
        test_reset();
        test_write_burst();
        test_round_robin();
        test_read_return();
        test_max_burst();
        test_back_to_back();
        test_reset_midburst();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
